// File: rtl/config_loader_pkg.sv
// -----------------------------------------------------------------------------
// config_loader_pkg
// Shared types and default parameter values for the serial configuration
// loader: the controller state encoding, frame length, expected header nibble
// and guard length.
// -----------------------------------------------------------------------------
package config_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK,
        GUARD
    } state_t;

    localparam int unsigned FRAME_BITS_DEFAULT   = 12;
    localparam logic [3:0]  HEADER_DEFAULT       = 4'hA;
    localparam int unsigned GUARD_CYCLES_DEFAULT = 8;

    // Width of the received-bit counter; it saturates at FRAME_BITS+1.
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer that brings one asynchronous pin into the clock domain.
// Ports:
//   clock   - destination clock
//   reset_n - asynchronous active-low reset, clears both stages
//   d       - asynchronous input
//   q       - synchronized output (two cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/config_loader.sv
// -----------------------------------------------------------------------------
// config_loader
// Receives a serial configuration frame on asynchronous pins, validates it and
// drives the design-select multiplexer controls. Frame, MSB first:
//   [11:8] header, [7:2] des_sel, [1] hold, [0] sync.
// After a good frame all unselected designs are held for GUARD_CYCLES cycles
// before the frame's hold bit is applied.
// Ports:
//   clock, reset_n   - clock and asynchronous active-low reset
//   cfg_en           - async; high frames one transfer
//   cfg_sclk         - async; shift strobe (rising edge shifts)
//   cfg_data         - async; serial data
//   des_sel          - selected design index
//   hold_if_not_sel  - hold-unselected control
//   sync_inputs      - input-sync enable
//   cfg_busy         - high while a frame is being received, checked or guarded
//   cfg_err          - sticky flag, set by a rejected frame, cleared by a good one
//   cfg_loaded       - set once any frame has committed
// -----------------------------------------------------------------------------
module config_loader
    import config_loader_pkg::*;
#(
    parameter int unsigned FRAME_BITS   = FRAME_BITS_DEFAULT,
    parameter logic [3:0]  HEADER       = HEADER_DEFAULT,
    parameter int unsigned GUARD_CYCLES = GUARD_CYCLES_DEFAULT
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       cfg_en,
    input  logic       cfg_sclk,
    input  logic       cfg_data,
    output logic [5:0] des_sel,
    output logic       hold_if_not_sel,
    output logic       sync_inputs,
    output logic       cfg_busy,
    output logic       cfg_err,
    output logic       cfg_loaded
);

    localparam int unsigned      GW         = $clog2(GUARD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(FRAME_BITS + 1);
    localparam logic [GW-1:0]    GUARD_LAST = GW'(GUARD_CYCLES - 1);

    logic en_s, sclk_s, data_s;
    logic en_prev, sclk_prev;
    logic en_rise, sclk_pulse;

    state_t                 state;
    logic [FRAME_BITS-1:0]  shreg;
    logic [CNT_W-1:0]       bit_cnt;
    logic [GW-1:0]          guard_cnt;
    logic                   hold_frame;
    logic                   frame_good;

    sync_2ff u_sync_en   (.clock(clock), .reset_n(reset_n), .d(cfg_en),   .q(en_s));
    sync_2ff u_sync_sclk (.clock(clock), .reset_n(reset_n), .d(cfg_sclk), .q(sclk_s));
    sync_2ff u_sync_data (.clock(clock), .reset_n(reset_n), .d(cfg_data), .q(data_s));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            en_prev   <= 1'b0;
            sclk_prev <= 1'b0;
        end else begin
            en_prev   <= en_s;
            sclk_prev <= sclk_s;
        end
    end

    assign en_rise    = en_s & ~en_prev;
    assign sclk_pulse = sclk_s & ~sclk_prev;

    // A saturated counter (FRAME_BITS+1) marks an over-long frame as bad even
    // though the shift register only keeps the most recent FRAME_BITS bits.
    assign frame_good = (bit_cnt == CNT_FULL) &&
                        (shreg[FRAME_BITS-1 -: 4] == HEADER);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            shreg           <= '0;
            bit_cnt         <= '0;
            guard_cnt       <= '0;
            hold_frame      <= 1'b1;
            des_sel         <= '0;
            hold_if_not_sel <= 1'b1;
            sync_inputs     <= 1'b1;
            cfg_busy        <= 1'b0;
            cfg_err         <= 1'b0;
            cfg_loaded      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Enable edges outside IDLE are never remembered, so a new
                    // transfer always needs a fresh rising edge seen here.
                    if (en_rise) begin
                        state    <= SHIFT;
                        shreg    <= '0;
                        bit_cnt  <= '0;
                        cfg_busy <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (!en_s) begin
                        state <= CHECK;
                    end else if (sclk_pulse) begin
                        shreg <= {shreg[FRAME_BITS-2:0], data_s};
                        if (bit_cnt != CNT_SAT) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (frame_good) begin
                        des_sel         <= shreg[7:2];
                        sync_inputs     <= shreg[0];
                        hold_frame      <= shreg[1];
                        hold_if_not_sel <= 1'b1;
                        cfg_err         <= 1'b0;
                        cfg_loaded      <= 1'b1;
                        guard_cnt       <= '0;
                        state           <= GUARD;
                    end else begin
                        cfg_err  <= 1'b1;
                        cfg_busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                GUARD: begin
                    if (guard_cnt == GUARD_LAST) begin
                        hold_if_not_sel <= hold_frame;
                        cfg_busy        <= 1'b0;
                        state           <= IDLE;
                    end else begin
                        guard_cnt <= guard_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cfg_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
